// File: rtl/stream_merge_arbiter_pkg.sv
// Shared AXIS widths, arbiter state encoding and beat container for the egress merge arbiter.
package stream_merge_arbiter_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = 64;
  localparam int AXIS_USER_W = 137;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [AXIS_USER_W-1:0] user;
    logic                   last;
  } beat_t;

  // Round-robin choice; returns 1 when s01 should be granted. last_s01 = s01 won the previous packet.
  function automatic logic rr_pick_s01(input logic req0, input logic req1, input logic last_s01);
    if (req0 && req1) return !last_s01;
    return req1;
  endfunction

endpackage

// File: rtl/stream_merge_arbiter_axis_out_reg.sv
// Single-stage AXIS output register; accepts a new beat whenever empty or draining this cycle.
module stream_merge_arbiter_axis_out_reg
  import stream_merge_arbiter_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  beat_t in_beat,
  input  logic  in_vld,
  output logic  in_rdy,
  output beat_t out_beat,
  output logic  out_vld,
  input  logic  out_rdy
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_beat <= '0;
      out_vld  <= 1'b0;
    end else if (in_vld) begin
      out_beat <= in_beat;
      out_vld  <= 1'b1;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_merge_arbiter.sv
// Packet-level 2:1 AXIS arbiter merging the protocol-processor and host-FIFO return streams onto one egress.
module stream_merge_arbiter
  import stream_merge_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [AXIS_DATA_W-1:0] s00_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s00_axis_tkeep,
  input  logic [AXIS_USER_W-1:0] s00_axis_tuser,
  input  logic                   s00_axis_tlast,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic [AXIS_DATA_W-1:0] s01_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s01_axis_tkeep,
  input  logic [AXIS_USER_W-1:0] s01_axis_tuser,
  input  logic                   s01_axis_tlast,
  input  logic                   s01_axis_tvalid,
  output logic                   s01_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic [AXIS_USER_W-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            pkt_cnt0,
  output logic [31:0]            pkt_cnt1
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       grant_s01;
  logic       out_rdy, acc0, acc1, done0, done1;
  beat_t      in_beat, out_beat;

  assign s00_axis_tready = (state_q == ST_GRANT0) && out_rdy;
  assign s01_axis_tready = (state_q == ST_GRANT1) && out_rdy;
  assign acc0  = s00_axis_tvalid && s00_axis_tready;
  assign acc1  = s01_axis_tvalid && s01_axis_tready;
  assign done0 = acc0 && s00_axis_tlast;
  assign done1 = acc1 && s01_axis_tlast;

  always_comb begin
    in_beat.data = s00_axis_tdata;
    in_beat.keep = s00_axis_tkeep;
    in_beat.user = s00_axis_tuser;
    in_beat.last = s00_axis_tlast;
    if (state_q == ST_GRANT1) begin
      in_beat.data = s01_axis_tdata;
      in_beat.keep = s01_axis_tkeep;
      in_beat.user = s01_axis_tuser;
      in_beat.last = s01_axis_tlast;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    grant_s01    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (PRIORITY_MODE == 0) begin
          grant_s01 = rr_pick_s01(s00_axis_tvalid, s01_axis_tvalid, last_grant_q);
        end else if (s00_axis_tvalid && s01_axis_tvalid) begin
          grant_s01 = (starve_cnt_q == STARVE_MAX);
          if (grant_s01) starve_cnt_d = 8'd0;
        end else begin
          grant_s01 = s01_axis_tvalid;
        end
        if (s00_axis_tvalid || s01_axis_tvalid) state_d = grant_s01 ? ST_GRANT1 : ST_GRANT0;
      end
      ST_GRANT0: begin
        if (done0) begin
          state_d      = ST_IDLE;
          last_grant_d = 1'b0;
          // s01 waited through this whole packet: one step closer to a forced grant
          if (s01_axis_tvalid && starve_cnt_q < STARVE_MAX) starve_cnt_d = starve_cnt_q + 8'd1;
        end
      end
      ST_GRANT1: begin
        if (done1) begin
          state_d      = ST_IDLE;
          last_grant_d = 1'b1;
          starve_cnt_d = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      starve_cnt_q <= 8'd0;
      pkt_cnt0     <= 32'd0;
      pkt_cnt1     <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      if (done0) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (done1) pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end
  end

  stream_merge_arbiter_axis_out_reg u_out_reg (
    .CLK      (CLK),
    .RST      (RST),
    .in_beat  (in_beat),
    .in_vld   (acc0 || acc1),
    .in_rdy   (out_rdy),
    .out_beat (out_beat),
    .out_vld  (m_axis_tvalid),
    .out_rdy  (m_axis_tready)
  );

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tkeep = out_beat.keep;
  assign m_axis_tuser = out_beat.user;
  assign m_axis_tlast = out_beat.last;

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Scoreboard bench: a round-robin instance and a fixed-priority (limit 2) instance run side by side.
module tb_stream_merge_arbiter;
  import stream_merge_arbiter_pkg::*;

  localparam int LIMIT = 2;

  logic  CLK;
  logic  RST;
  beat_t s_beat  [2][2];
  logic  s_valid [2][2];
  wire   s_ready [2][2];
  wire [AXIS_DATA_W-1:0] m_data [2];
  wire [AXIS_KEEP_W-1:0] m_keep [2];
  wire [AXIS_USER_W-1:0] m_user [2];
  wire   m_last  [2];
  wire   m_valid [2];
  logic  m_ready [2];
  wire [31:0] cnt0 [2];
  wire [31:0] cnt1 [2];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  stream_merge_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .CLK(CLK), .RST(RST),
    .s00_axis_tdata(s_beat[0][0].data), .s00_axis_tkeep(s_beat[0][0].keep),
    .s00_axis_tuser(s_beat[0][0].user), .s00_axis_tlast(s_beat[0][0].last),
    .s00_axis_tvalid(s_valid[0][0]), .s00_axis_tready(s_ready[0][0]),
    .s01_axis_tdata(s_beat[0][1].data), .s01_axis_tkeep(s_beat[0][1].keep),
    .s01_axis_tuser(s_beat[0][1].user), .s01_axis_tlast(s_beat[0][1].last),
    .s01_axis_tvalid(s_valid[0][1]), .s01_axis_tready(s_ready[0][1]),
    .m_axis_tdata(m_data[0]), .m_axis_tkeep(m_keep[0]), .m_axis_tuser(m_user[0]),
    .m_axis_tlast(m_last[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
    .pkt_cnt0(cnt0[0]), .pkt_cnt1(cnt1[0])
  );

  stream_merge_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(LIMIT)) u_fp (
    .CLK(CLK), .RST(RST),
    .s00_axis_tdata(s_beat[1][0].data), .s00_axis_tkeep(s_beat[1][0].keep),
    .s00_axis_tuser(s_beat[1][0].user), .s00_axis_tlast(s_beat[1][0].last),
    .s00_axis_tvalid(s_valid[1][0]), .s00_axis_tready(s_ready[1][0]),
    .s01_axis_tdata(s_beat[1][1].data), .s01_axis_tkeep(s_beat[1][1].keep),
    .s01_axis_tuser(s_beat[1][1].user), .s01_axis_tlast(s_beat[1][1].last),
    .s01_axis_tvalid(s_valid[1][1]), .s01_axis_tready(s_ready[1][1]),
    .m_axis_tdata(m_data[1]), .m_axis_tkeep(m_keep[1]), .m_axis_tuser(m_user[1]),
    .m_axis_tlast(m_last[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
    .pkt_cnt0(cnt0[1]), .pkt_cnt1(cnt1[1])
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  beat_t src_q [2][2][$];
  beat_t exp_q [2][$];
  int    exp_cnt [2][2];
  int    mdl_lastg [2];
  int    mdl_starve [2];
  int    n_s00 [2];
  logic  acc [2][2];
  logic  mid [2][2];
  int    cyc = 0;
  int    last_done [2];
  bit    have_prev [2];

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input beat_t act, input beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got data=%0h last=%0b expected data=%0h last=%0b", name,
               act.data[63:0], act.last, exp.data[63:0], exp.last);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every egress handshake, checks AXIS stability and ready rules.
  beat_t snap [2];
  bit    snap_stall [2];
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      beat_t cur;
      beat_t e;
      cur = {m_data[d], m_keep[d], m_user[d], m_last[d]};
      if (RST !== 1'b1) begin
        snap_stall[d] = 1'b0;
      end else begin
        if (snap_stall[d]) begin
          check_int($sformatf("stall_valid_d%0d", d), int'(m_valid[d]), 1);
          check_beat($sformatf("stall_stable_d%0d", d), cur, snap[d]);
        end
        check_int($sformatf("one_ready_d%0d", d), int'(s_ready[d][0] && s_ready[d][1]), 0);
        if (m_valid[d] && !m_ready[d])
          check_int($sformatf("stall_tready_d%0d", d), int'({s_ready[d][0], s_ready[d][1]}), 0);
        if (m_valid[d] && m_ready[d]) begin
          if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_beat_d%0d: got data=%0h expected no beat", d, cur.data[63:0]);
          end else begin
            e = exp_q[d].pop_front();
            check_beat($sformatf("beat_d%0d", d), cur, e);
          end
        end
        snap[d]       = cur;
        snap_stall[d] = m_valid[d] && !m_ready[d];
      end
    end
  end

  task automatic add_pkts(input int d, input int s, input int n, input int lmin, input int lmax);
    for (int p = 0; p < n; p++) begin
      int len;
      len = $urandom_range(lmax, lmin);
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        logic [511:0] u;
        u       = rnd512();
        bt.data = rnd512();
        bt.keep = {$urandom, $urandom};
        bt.user = u[136:0];
        bt.last = (b == len - 1);
        src_q[d][s].push_back(bt);
      end
    end
    if (s == 0) n_s00[d] += n;
  endtask

  // Reference model: replays the packet-level grant rules over the queued packets.
  task automatic build_expected(input int d);
    int    idx [2];
    int    g;
    bit    r0, r1;
    beat_t b;
    idx[0] = 0;
    idx[1] = 0;
    while (idx[0] < src_q[d][0].size() || idx[1] < src_q[d][1].size()) begin
      r0 = idx[0] < src_q[d][0].size();
      r1 = idx[1] < src_q[d][1].size();
      if (r0 && r1) begin
        if (d == 0) g = 1 - mdl_lastg[d];
        else if (mdl_starve[d] == LIMIT) begin
          g = 1;
          mdl_starve[d] = 0;
        end else g = 0;
      end else g = r1 ? 1 : 0;
      do begin
        b = src_q[d][g][idx[g]];
        idx[g]++;
        exp_q[d].push_back(b);
      end while (!b.last);
      mdl_lastg[d] = g;
      exp_cnt[d][g]++;
      if (g == 1) mdl_starve[d] = 0;
      else if (idx[1] < src_q[d][1].size() && mdl_starve[d] < LIMIT) mdl_starve[d]++;
    end
  endtask

  task automatic flush_all();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      have_prev[d] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        src_q[d][s].delete();
        s_valid[d][s] = 1'b0;
        acc[d][s] = 1'b0;
        mid[d][s] = 1'b0;
      end
    end
  endtask

  task automatic async_reset();
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_int($sformatf("rst_async_tvalid_d%0d", d), int'(m_valid[d]), 0);
      check_int($sformatf("rst_async_cnt0_d%0d", d), int'(cnt0[d]), 0);
      check_int($sformatf("rst_async_cnt1_d%0d", d), int'(cnt1[d]), 0);
      check_int($sformatf("rst_async_tready_d%0d", d), int'({s_ready[d][0], s_ready[d][1]}), 0);
      mdl_lastg[d] = 1;
      mdl_starve[d] = 0;
      exp_cnt[d][0] = 0;
      exp_cnt[d][1] = 0;
    end
    flush_all();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic run_phase(input string tag, input int rpct, input bit do_reset);
    int c;
    beat_t b;
    c = 0;
    for (int d = 0; d < 2; d++) begin
      build_expected(d);
      have_prev[d] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        acc[d][s] = 1'b0;
        mid[d][s] = 1'b0;
      end
    end
    forever begin
      @(posedge CLK);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 2; s++) begin
          if (acc[d][s]) begin
            b = src_q[d][s].pop_front();
            mid[d][s] = !b.last;
          end
          if (!(s_valid[d][s] && !acc[d][s])) begin
            if (src_q[d][s].size() == 0) s_valid[d][s] = 1'b0;
            else begin
              s_beat[d][s]  = src_q[d][s][0];
              s_valid[d][s] = !mid[d][s] || ($urandom_range(3, 0) != 0);
            end
          end
        end
        m_ready[d] = ($urandom_range(99, 0) < rpct);
      end
      @(negedge CLK);
      cyc++;
      c++;
      for (int d = 0; d < 2; d++) begin
        if (n_s00[d] == 0) check_int($sformatf("%s_s00_tready_d%0d", tag, d), int'(s_ready[d][0]), 0);
        for (int s = 0; s < 2; s++) begin
          acc[d][s] = s_valid[d][s] && s_ready[d][s];
          if (acc[d][s] && !mid[d][s] && have_prev[d]) begin
            if (rpct == 100) check_int($sformatf("%s_bubble_d%0d", tag, d), cyc - last_done[d], 2);
            else check_int($sformatf("%s_bubble_min_d%0d", tag, d), int'(cyc - last_done[d] >= 2), 1);
          end
          if (acc[d][s] && s_beat[d][s].last) begin
            last_done[d] = cyc;
            have_prev[d] = 1'b1;
          end
        end
      end
      if (do_reset && c >= 6 && m_valid[0]) begin
        async_reset();
        break;
      end
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && src_q[0][0].size() == 0 &&
          src_q[0][1].size() == 0 && src_q[1][0].size() == 0 && src_q[1][1].size() == 0) begin
        for (int d = 0; d < 2; d++) begin
          check_int($sformatf("%s_pkt_cnt0_d%0d", tag, d), int'(cnt0[d]), exp_cnt[d][0]);
          check_int($sformatf("%s_pkt_cnt1_d%0d", tag, d), int'(cnt1[d]), exp_cnt[d][1]);
        end
        break;
      end
      if (c >= 4000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got %0d beats pending expected 0", tag, exp_q[0].size() + exp_q[1].size());
        flush_all();
        break;
      end
    end
    for (int d = 0; d < 2; d++) n_s00[d] = 0;
  endtask

  initial begin
    RST = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_ready[d] = 1'b0;
      mdl_lastg[d] = 1;
      mdl_starve[d] = 0;
      n_s00[d] = 0;
      exp_cnt[d][0] = 0;
      exp_cnt[d][1] = 0;
      last_done[d] = 0;
      for (int s = 0; s < 2; s++) s_beat[d][s] = '0;
    end
    flush_all();
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      check_int($sformatf("rst_tvalid_d%0d", d), int'(m_valid[d]), 0);
      check_int($sformatf("rst_tlast_d%0d", d), int'(m_last[d]), 0);
      check_int($sformatf("rst_tdata_zero_d%0d", d), int'(m_data[d] == '0 && m_user[d] == '0), 1);
      check_int($sformatf("rst_tready_d%0d", d), int'({s_ready[d][0], s_ready[d][1]}), 0);
      check_int($sformatf("rst_cnt0_d%0d", d), int'(cnt0[d]), 0);
      check_int($sformatf("rst_cnt1_d%0d", d), int'(cnt1[d]), 0);
    end
    RST = 1'b1;

    // Single source: one 3-beat s01 packet tagged 1,2,3
    for (int b = 1; b <= 3; b++) begin
      beat_t bt;
      bt = '0;
      bt.data = rnd512();
      bt.data[63:0] = 64'(b);
      bt.keep = {$urandom, $urandom};
      bt.last = (b == 3);
      src_q[0][1].push_back(bt);
    end
    run_phase("t1", 100, 1'b0);

    // Both sources continuously offering: 2-beat then 1-beat packets
    for (int d = 0; d < 2; d++) begin
      add_pkts(d, 0, 3, 2, 2);
      add_pkts(d, 1, 3, 2, 2);
    end
    run_phase("t2", 100, 1'b0);
    for (int d = 0; d < 2; d++) begin
      add_pkts(d, 0, 6, 1, 1);
      add_pkts(d, 1, 3, 1, 1);
    end
    run_phase("t4", 100, 1'b0);

    // Randomized traffic under varying backpressure
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 2; d++) begin
        add_pkts(d, 0, $urandom_range(8, 1), 1, 4);
        add_pkts(d, 1, $urandom_range(8, 1), 1, 4);
      end
      run_phase($sformatf("rnd%0d", r), (r == 0) ? 100 : (r == 1) ? 70 : 35, 1'b0);
    end

    // Asynchronous reset mid-packet, then a clean restart
    for (int d = 0; d < 2; d++) begin
      add_pkts(d, 0, 4, 3, 4);
      add_pkts(d, 1, 4, 3, 4);
    end
    run_phase("t6", 80, 1'b1);
    for (int d = 0; d < 2; d++) begin
      add_pkts(d, 0, $urandom_range(6, 2), 1, 4);
      add_pkts(d, 1, $urandom_range(6, 2), 1, 4);
    end
    run_phase("restart", 60, 1'b0);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
